lsu: RTL and testbench
======================

# lsu

Load/store unit between the single-cycle RISC-V `datapath` and the data-memory bus. It takes the datapath's effective address (`alu_out`) and store data (`write_data`) and runs a req/ack bus transaction with byte-lane enables. It returns sign- or zero-extended load data as `read_data` and stalls the core until the access completes. Misaligned accesses and bus timeouts are reported as errors without hanging the core.

## Interface
Parameters:
- `TIMEOUT`, 16: maximum number of BUS cycles to wait for `bus_ack` before aborting. Legal range is 1–255.

Ports:
- `clk` in 1: clock, rising edge.
- `rst` in 1: asynchronous, active-low reset.
- `req_valid` in 1: the current instruction is a load or store.
- `req_we` in 1: 1 = store, 0 = load.
- `req_size` in 2: `mem_size_byte`=00, `mem_size_half`=01, `mem_size_word`=10; 11 is reserved.
- `req_unsigned` in 1: zero-extend the load (LBU/LHU).
- `addr` in 32: effective byte address.
- `wdata` in 32: store data, taken from the low bits.
- `read_data` out 32: extended load data. Registered; reset value 0.
- `stall` out 1: hold PC and suppress the register-file write. Combinational.
- `done` out 1: access completed. One-cycle pulse; reset value 0.
- `err` out 1: misaligned access, reserved size, or timeout. Valid with `done`; reset value 0.
- `bus_req` out 1: transaction request. Registered; reset value 0.
- `bus_we` out 1: bus write. Reset value 0.
- `bus_addr` out 32: word-aligned address (`{addr[31:2],2'b00}`). Reset value 0.
- `bus_be` out 4: byte enables. Reset value 0.
- `bus_wdata` out 32: lane-replicated store data. Reset value 0.
- `bus_ack` in 1: slave completion; sampled only in BUS.
- `bus_rdata` in 32: read data, valid in the `bus_ack` cycle.

## Operation
State machine: IDLE, BUS, RESP.

IDLE:
- `req_valid`=1 with a legal, aligned request: latch `bus_addr`, `bus_we`, `bus_be`, `bus_wdata`, `addr[1:0]`, size and unsigned flag; set `bus_req`=1; go to BUS.
- `req_valid`=1 with a misaligned or reserved-size request: no bus activity; set `err`=1 and `read_data`=0; go to RESP.

BUS:
- All `bus_*` outputs stay stable.
- `bus_ack`=1: capture the extended load data into `read_data` (stores leave it at 0), drop `bus_req`, go to RESP.
- Timeout: the counter is cleared on BUS entry and incremented each BUS cycle without ack. When it reaches `TIMEOUT` without ack, drop `bus_req`, set `err`=1, go to RESP.

RESP:
- `done`=1 for one cycle, then return to IDLE.
- Any `req_valid` seen in RESP is ignored; it belongs to the instruction committing at this edge.

Stall:
- `stall` = (IDLE && `req_valid`) || BUS.
- `stall` is low in RESP, so the core commits the write-back and PC update at the end of RESP.

Alignment:
- Half requires `addr[0]`=0.
- Word requires `addr[1:0]`=0.
- Byte is always aligned.

Lane rules (`o` = `addr[1:0]`):
- Byte: `bus_be`=`4'b0001<<o`, `bus_wdata`=`{4{wdata[7:0]}}`, load = `bus_rdata[8*o +: 8]`.
- Half: `bus_be`=`4'b0011<<o`, `bus_wdata`=`{2{wdata[15:0]}}`, load = `bus_rdata[8*o +: 16]`.
- Word: `bus_be`=`4'hF`, `bus_wdata`=`wdata`, load = `bus_rdata`.
- Extension: sign-extend unless `req_unsigned`=1. Word loads ignore `req_unsigned`.

Boundary conditions:
- `bus_ack` in IDLE or RESP is ignored.
- Ack arriving in the same cycle the timeout expires: the ack wins, no error.
- Reset asserted mid-transaction: all outputs clear asynchronously (`bus_req` drops at once) and the state returns to IDLE.

## Timing
- Bus outputs are registered: `bus_req` rises one cycle after the accepting IDLE edge.
- Minimum access (ack in the first BUS cycle) is 3 cycles: IDLE, BUS, RESP. `stall` is high for 2 cycles.
- Each BUS cycle without ack adds one cycle of latency.
- Misaligned access: 2 cycles (IDLE, RESP), `stall` high for 1 cycle.
- Timeout: `TIMEOUT` BUS cycles, then RESP with `err`=1.
- Back-to-back accesses: the next request is accepted in the IDLE cycle immediately after RESP.

## Structure
- Shared header `riscv/lsu.vh`: `mem_size_*` codes and the `lsu_state` enum (`lsu_idle`, `lsu_bus`, `lsu_resp`).
- Sub-module `lsu_lanes` (combinational), covering:
  - alignment check
  - `bus_be` generation
  - `bus_wdata` replication
  - load-lane extraction and extension
- `lsu` itself contains the FSM, timeout counter and output registers.

## Test plan
- LW from `addr`=0x100, ack in the first BUS cycle, `bus_rdata`=0xDEADBEEF:
  - `bus_addr`=0x100, `bus_be`=F.
  - `done` in cycle 3 with `read_data`=0xDEADBEEF, `err`=0; `stall` high in cycles 1–2.
- LB from 0x103 with `bus_rdata`=0x80xxxxxx:
  - `bus_be`=8, `read_data`=0xFFFFFF80.
  - Same access as LBU: `read_data`=0x00000080.
- SH of `wdata`=0x1234ABCD to 0x202, ack after 3 wait cycles:
  - `bus_be`=C, `bus_wdata`=0xABCDABCD, `bus_we`=1.
  - Outputs stable throughout BUS; `done` 6 cycles after request.
- LW from 0x101: no `bus_req`, `done`=`err`=1 in the second cycle, `read_data`=0.
- `TIMEOUT`=4, no ack: `bus_req` high for 4 cycles, then `done`=`err`=1, then IDLE.
- Assert `rst` during BUS: `bus_req`=0 immediately, state IDLE. A later `bus_ack` is ignored and the next request completes normally.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: access-size codes, FSM state
// encoding and the alignment rule used when a request is accepted.
package lsu_pkg;

    localparam logic [1:0] mem_size_byte = 2'b00;
    localparam logic [1:0] mem_size_half = 2'b01;
    localparam logic [1:0] mem_size_word = 2'b10;

    typedef enum logic [1:0] {
        lsu_idle = 2'b00,
        lsu_bus  = 2'b01,
        lsu_resp = 2'b10
    } lsu_state_e;

    // True when the size code is legal and the byte offset suits that size.
    function automatic logic is_aligned(input logic [1:0] size, input logic [1:0] off);
        logic ok;
        case (size)
            mem_size_byte: ok = 1'b1;
            mem_size_half: ok = (off[0] == 1'b0);
            mem_size_word: ok = (off == 2'b00);
            default:       ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/lsu_lanes.sv
// Byte-lane logic for the load/store unit: request legality, byte enables,
// store-data replication, and load-lane extraction with sign/zero extension.
module lsu_lanes
    import lsu_pkg::*;
(
    input  logic [1:0]  req_size,
    input  logic [1:0]  req_off,
    input  logic [31:0] wdata,
    output logic        req_ok,
    output logic [3:0]  be,
    output logic [31:0] wdata_rep,
    input  logic [1:0]  ld_size,
    input  logic        ld_unsigned,
    input  logic [1:0]  ld_off,
    input  logic [31:0] rdata,
    output logic [31:0] load_data
);

    logic [31:0] shifted_s;

    // Request side: legality, byte enables and replicated store data.
    always_comb begin
        req_ok    = is_aligned(req_size, req_off);
        be        = 4'b0000;
        wdata_rep = 32'h0000_0000;
        case (req_size)
            mem_size_byte: begin
                be        = 4'b0001 << req_off;
                wdata_rep = {4{wdata[7:0]}};
            end
            mem_size_half: begin
                be        = 4'b0011 << req_off;
                wdata_rep = {2{wdata[15:0]}};
            end
            mem_size_word: begin
                be        = 4'b1111;
                wdata_rep = wdata;
            end
            default: begin
                be        = 4'b0000;
                wdata_rep = 32'h0000_0000;
            end
        endcase
    end

    // Load side: move the addressed lane down to bit 0, then extend it.
    always_comb begin
        shifted_s = rdata >> {ld_off, 3'b000};
        load_data = 32'h0000_0000;
        case (ld_size)
            mem_size_byte: begin
                if (ld_unsigned) begin
                    load_data = {24'h00_0000, shifted_s[7:0]};
                end else begin
                    load_data = {{24{shifted_s[7]}}, shifted_s[7:0]};
                end
            end
            mem_size_half: begin
                if (ld_unsigned) begin
                    load_data = {16'h0000, shifted_s[15:0]};
                end else begin
                    load_data = {{16{shifted_s[15]}}, shifted_s[15:0]};
                end
            end
            mem_size_word: load_data = rdata;
            default:       load_data = 32'h0000_0000;
        endcase
    end

endmodule

// File: rtl/lsu.sv
// Load/store unit: accepts a load/store from the datapath, runs a req/ack
// bus transaction with byte enables, returns extended load data and stalls
// the core until completion. Misalignment and bus timeouts end in RESP with
// err set, so the core never hangs.
module lsu
    import lsu_pkg::*;
#(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    input  logic        req_we,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] read_data,
    output logic        stall,
    output logic        done,
    output logic        err,
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [3:0]  bus_be,
    output logic [31:0] bus_wdata,
    input  logic        bus_ack,
    input  logic [31:0] bus_rdata
);

    // Counter value in the last BUS cycle before the access is abandoned.
    localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT - 1);

    lsu_state_e  state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [31:0] read_data_q, read_data_d;
    logic        done_q, done_d;
    logic        err_q, err_d;
    logic        bus_req_q, bus_req_d;
    logic        bus_we_q, bus_we_d;
    logic [31:0] bus_addr_q, bus_addr_d;
    logic [3:0]  bus_be_q, bus_be_d;
    logic [31:0] bus_wdata_q, bus_wdata_d;
    logic [1:0]  off_q, off_d;
    logic [1:0]  size_q, size_d;
    logic        uns_q, uns_d;

    logic        req_ok_s;
    logic [3:0]  be_s;
    logic [31:0] wdata_rep_s;
    logic [31:0] load_s;

    lsu_lanes u_lanes (
        .req_size    (req_size),
        .req_off     (addr[1:0]),
        .wdata       (wdata),
        .req_ok      (req_ok_s),
        .be          (be_s),
        .wdata_rep   (wdata_rep_s),
        .ld_size     (size_q),
        .ld_unsigned (uns_q),
        .ld_off      (off_q),
        .rdata       (bus_rdata),
        .load_data   (load_s)
    );

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= lsu_idle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; an ack takes priority over an expiring timeout.
    always_comb begin
        state_d = state_q;
        case (state_q)
            lsu_idle: begin
                if (req_valid) begin
                    if (req_ok_s) begin
                        state_d = lsu_bus;
                    end else begin
                        state_d = lsu_resp;
                    end
                end else begin
                    state_d = lsu_idle;
                end
            end
            lsu_bus: begin
                if (bus_ack) begin
                    state_d = lsu_resp;
                end else if (cnt_q == TIMEOUT_LAST) begin
                    state_d = lsu_resp;
                end else begin
                    state_d = lsu_bus;
                end
            end
            lsu_resp: state_d = lsu_idle;
            default:  state_d = lsu_idle;
        endcase
    end

    // Output/datapath next values: bus fields hold while in BUS, done/err
    // are raised only on the edge that enters RESP.
    always_comb begin
        cnt_d       = cnt_q;
        read_data_d = read_data_q;
        done_d      = 1'b0;
        err_d       = 1'b0;
        bus_req_d   = bus_req_q;
        bus_we_d    = bus_we_q;
        bus_addr_d  = bus_addr_q;
        bus_be_d    = bus_be_q;
        bus_wdata_d = bus_wdata_q;
        off_d       = off_q;
        size_d      = size_q;
        uns_d       = uns_q;
        case (state_q)
            lsu_idle: begin
                if (req_valid) begin
                    if (req_ok_s) begin
                        bus_req_d   = 1'b1;
                        bus_we_d    = req_we;
                        bus_addr_d  = {addr[31:2], 2'b00};
                        bus_be_d    = be_s;
                        bus_wdata_d = wdata_rep_s;
                        off_d       = addr[1:0];
                        size_d      = req_size;
                        uns_d       = req_unsigned;
                        cnt_d       = 8'd0;
                    end else begin
                        done_d      = 1'b1;
                        err_d       = 1'b1;
                        read_data_d = 32'h0000_0000;
                    end
                end else begin
                    cnt_d = cnt_q;
                end
            end
            lsu_bus: begin
                if (bus_ack) begin
                    bus_req_d = 1'b0;
                    done_d    = 1'b1;
                    if (bus_we_q) begin
                        read_data_d = 32'h0000_0000;
                    end else begin
                        read_data_d = load_s;
                    end
                end else if (cnt_q == TIMEOUT_LAST) begin
                    bus_req_d   = 1'b0;
                    done_d      = 1'b1;
                    err_d       = 1'b1;
                    read_data_d = 32'h0000_0000;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            lsu_resp: begin
                done_d = 1'b0;
            end
            default: begin
                bus_req_d = 1'b0;
            end
        endcase
    end

    // Output and request-context registers, cleared asynchronously.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q       <= 8'd0;
            read_data_q <= 32'h0000_0000;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            bus_req_q   <= 1'b0;
            bus_we_q    <= 1'b0;
            bus_addr_q  <= 32'h0000_0000;
            bus_be_q    <= 4'b0000;
            bus_wdata_q <= 32'h0000_0000;
            off_q       <= 2'b00;
            size_q      <= 2'b00;
            uns_q       <= 1'b0;
        end else begin
            cnt_q       <= cnt_d;
            read_data_q <= read_data_d;
            done_q      <= done_d;
            err_q       <= err_d;
            bus_req_q   <= bus_req_d;
            bus_we_q    <= bus_we_d;
            bus_addr_q  <= bus_addr_d;
            bus_be_q    <= bus_be_d;
            bus_wdata_q <= bus_wdata_d;
            off_q       <= off_d;
            size_q      <= size_d;
            uns_q       <= uns_d;
        end
    end

    // Stall the core while a request waits in IDLE or a bus access is open.
    always_comb begin
        stall = ((state_q == lsu_idle) && req_valid) || (state_q == lsu_bus);
    end

    assign read_data = read_data_q;
    assign done      = done_q;
    assign err       = err_q;
    assign bus_req   = bus_req_q;
    assign bus_we    = bus_we_q;
    assign bus_addr  = bus_addr_q;
    assign bus_be    = bus_be_q;
    assign bus_wdata = bus_wdata_q;

endmodule

// File: tb/tb_lsu.sv
// Directed test of the load/store unit with TIMEOUT=4. Inputs change just
// after the rising edge; outputs are checked on the falling edge.
module tb_lsu;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, req_we, req_unsigned;
    logic [1:0]  req_size;
    logic [31:0] addr, wdata;
    logic [31:0] read_data;
    logic        stall, done, err;
    logic        bus_req, bus_we;
    logic [31:0] bus_addr, bus_wdata;
    logic [3:0]  bus_be;
    logic        bus_ack;
    logic [31:0] bus_rdata;

    int n_chk  = 0;
    int n_fail = 0;

    lsu #(.TIMEOUT(4)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_we(req_we), .req_size(req_size),
        .req_unsigned(req_unsigned), .addr(addr), .wdata(wdata),
        .read_data(read_data), .stall(stall), .done(done), .err(err),
        .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr),
        .bus_be(bus_be), .bus_wdata(bus_wdata),
        .bus_ack(bus_ack), .bus_rdata(bus_rdata)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        @(negedge clk);
    endtask

    task automatic issue(input logic we, input logic [1:0] sz, input logic uns,
                         input logic [31:0] a, input logic [31:0] wd);
        req_valid    = 1'b1;
        req_we       = we;
        req_size     = sz;
        req_unsigned = uns;
        addr         = a;
        wdata        = wd;
    endtask

    task automatic idle_inputs();
        req_valid = 1'b0;
        bus_ack   = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b0;
        req_valid = 1'b0; req_we = 1'b0; req_size = 2'b00; req_unsigned = 1'b0;
        addr = 32'h0; wdata = 32'h0; bus_ack = 1'b0; bus_rdata = 32'h0;
        repeat (2) next_cycle();
        mid();
        chk("rst_read_data", read_data, 32'h0);
        chk("rst_done", done, 32'h0);
        chk("rst_err", err, 32'h0);
        chk("rst_bus_req", bus_req, 32'h0);
        chk("rst_bus_we", bus_we, 32'h0);
        chk("rst_bus_addr", bus_addr, 32'h0);
        chk("rst_bus_be", bus_be, 32'h0);
        chk("rst_bus_wdata", bus_wdata, 32'h0);
        chk("rst_stall", stall, 32'h0);
        rst = 1'b1;

        // LW 0x100, ack in first BUS cycle
        next_cycle(); issue(1'b0, 2'b10, 1'b0, 32'h100, 32'h0);
        mid(); chk("lw_c1_stall", stall, 32'h1); chk("lw_c1_bus_req", bus_req, 32'h0);
        next_cycle(); bus_ack = 1'b1; bus_rdata = 32'hDEAD_BEEF;
        mid();
        chk("lw_c2_bus_req", bus_req, 32'h1); chk("lw_c2_bus_addr", bus_addr, 32'h100);
        chk("lw_c2_bus_be", bus_be, 32'hF); chk("lw_c2_bus_we", bus_we, 32'h0);
        chk("lw_c2_stall", stall, 32'h1); chk("lw_c2_done", done, 32'h0);
        next_cycle(); bus_ack = 1'b0;
        mid();
        chk("lw_c3_done", done, 32'h1); chk("lw_c3_err", err, 32'h0);
        chk("lw_c3_read_data", read_data, 32'hDEAD_BEEF);
        chk("lw_c3_stall", stall, 32'h0); chk("lw_c3_bus_req", bus_req, 32'h0);
        next_cycle(); idle_inputs();
        mid(); chk("lw_c4_done", done, 32'h0); chk("lw_c4_stall", stall, 32'h0);

        // LB 0x103 signed
        next_cycle(); issue(1'b0, 2'b00, 1'b0, 32'h103, 32'h0);
        mid(); chk("lb_c1_stall", stall, 32'h1);
        next_cycle(); bus_ack = 1'b1; bus_rdata = 32'h8012_3456;
        mid(); chk("lb_bus_be", bus_be, 32'h8); chk("lb_bus_addr", bus_addr, 32'h100);
        next_cycle(); bus_ack = 1'b0;
        mid(); chk("lb_done", done, 32'h1); chk("lb_read_data", read_data, 32'hFFFF_FF80);

        // LBU 0x103, issued back-to-back in the IDLE cycle right after RESP
        next_cycle(); issue(1'b0, 2'b00, 1'b1, 32'h103, 32'h0);
        mid(); chk("lbu_c1_stall", stall, 32'h1); chk("lbu_c1_done", done, 32'h0);
        next_cycle(); bus_ack = 1'b1;
        mid(); chk("lbu_bus_req", bus_req, 32'h1); chk("lbu_bus_be", bus_be, 32'h8);
        next_cycle(); bus_ack = 1'b0;
        mid(); chk("lbu_done", done, 32'h1); chk("lbu_err", err, 32'h0);
        chk("lbu_read_data", read_data, 32'h0000_0080);

        // Misaligned LW 0x101
        next_cycle(); issue(1'b0, 2'b10, 1'b0, 32'h101, 32'h0);
        mid(); chk("mis_c1_stall", stall, 32'h1); chk("mis_c1_bus_req", bus_req, 32'h0);
        next_cycle();
        mid();
        chk("mis_done", done, 32'h1); chk("mis_err", err, 32'h1);
        chk("mis_read_data", read_data, 32'h0); chk("mis_bus_req", bus_req, 32'h0);
        chk("mis_stall", stall, 32'h0);

        // Reserved size code
        next_cycle(); issue(1'b0, 2'b11, 1'b0, 32'h200, 32'h0);
        mid(); chk("rsv_c1_stall", stall, 32'h1);
        next_cycle();
        mid(); chk("rsv_done", done, 32'h1); chk("rsv_err", err, 32'h1);
        chk("rsv_bus_req", bus_req, 32'h0);

        // Misaligned LH 0x103
        next_cycle(); issue(1'b0, 2'b01, 1'b0, 32'h103, 32'h0);
        next_cycle();
        mid(); chk("mish_done", done, 32'h1); chk("mish_err", err, 32'h1);

        // LH 0x102 signed
        next_cycle(); issue(1'b0, 2'b01, 1'b0, 32'h102, 32'h0);
        next_cycle(); bus_ack = 1'b1; bus_rdata = 32'h8001_1234;
        mid(); chk("lh_bus_be", bus_be, 32'hC);
        next_cycle(); bus_ack = 1'b0;
        mid(); chk("lh_done", done, 32'h1); chk("lh_read_data", read_data, 32'hFFFF_8001);
        next_cycle(); idle_inputs();

        // SH 0x1234ABCD to 0x202, ack after 3 wait cycles
        next_cycle(); issue(1'b1, 2'b01, 1'b0, 32'h202, 32'h1234_ABCD);
        mid(); chk("sh_c1_stall", stall, 32'h1);
        for (int i = 2; i <= 5; i++) begin
            next_cycle(); bus_ack = (i == 5);
            mid();
            chk($sformatf("sh_c%0d_bus_req", i), bus_req, 32'h1);
            chk($sformatf("sh_c%0d_bus_we", i), bus_we, 32'h1);
            chk($sformatf("sh_c%0d_bus_addr", i), bus_addr, 32'h200);
            chk($sformatf("sh_c%0d_bus_be", i), bus_be, 32'hC);
            chk($sformatf("sh_c%0d_bus_wdata", i), bus_wdata, 32'hABCD_ABCD);
            chk($sformatf("sh_c%0d_stall", i), stall, 32'h1);
            chk($sformatf("sh_c%0d_done", i), done, 32'h0);
        end
        next_cycle(); bus_ack = 1'b0;
        mid();
        chk("sh_c6_done", done, 32'h1); chk("sh_c6_err", err, 32'h0);
        chk("sh_c6_read_data", read_data, 32'h0); chk("sh_c6_bus_req", bus_req, 32'h0);
        next_cycle(); idle_inputs();

        // Timeout: LW 0x300 with no ack, TIMEOUT=4
        next_cycle(); issue(1'b0, 2'b10, 1'b0, 32'h300, 32'h0);
        for (int i = 2; i <= 5; i++) begin
            next_cycle();
            mid();
            chk($sformatf("to_c%0d_bus_req", i), bus_req, 32'h1);
            chk($sformatf("to_c%0d_stall", i), stall, 32'h1);
            chk($sformatf("to_c%0d_done", i), done, 32'h0);
        end
        next_cycle();
        mid();
        chk("to_done", done, 32'h1); chk("to_err", err, 32'h1);
        chk("to_bus_req", bus_req, 32'h0); chk("to_stall", stall, 32'h0);
        next_cycle(); idle_inputs();
        mid(); chk("to_idle_done", done, 32'h0); chk("to_idle_err", err, 32'h0);
        chk("to_idle_stall", stall, 32'h0);

        // Ack in the same cycle the timeout expires: ack wins
        next_cycle(); issue(1'b0, 2'b10, 1'b0, 32'h304, 32'h0); bus_rdata = 32'h0BAD_F00D;
        for (int i = 2; i <= 5; i++) begin
            next_cycle(); bus_ack = (i == 5);
            mid(); chk($sformatf("ae_c%0d_bus_req", i), bus_req, 32'h1);
        end
        next_cycle(); bus_ack = 1'b0;
        mid(); chk("ae_done", done, 32'h1); chk("ae_err", err, 32'h0);
        chk("ae_read_data", read_data, 32'h0BAD_F00D);
        next_cycle(); idle_inputs();

        // Ack while IDLE is ignored
        next_cycle(); bus_ack = 1'b1;
        mid(); chk("idle_ack_bus_req", bus_req, 32'h0); chk("idle_ack_stall", stall, 32'h0);
        next_cycle(); bus_ack = 1'b0;
        mid(); chk("idle_ack_done", done, 32'h0); chk("idle_ack_bus_req2", bus_req, 32'h0);

        // Reset asserted during BUS
        next_cycle(); issue(1'b0, 2'b10, 1'b0, 32'h400, 32'h0);
        next_cycle();
        mid(); chk("rb_bus_req_before", bus_req, 32'h1);
        req_valid = 1'b0; rst = 1'b0;
        #1;
        chk("rb_bus_req", bus_req, 32'h0); chk("rb_bus_addr", bus_addr, 32'h0);
        chk("rb_bus_be", bus_be, 32'h0); chk("rb_read_data", read_data, 32'h0);
        chk("rb_stall", stall, 32'h0);
        #1; rst = 1'b1;
        next_cycle(); bus_ack = 1'b1; bus_rdata = 32'h0000_0055;
        mid(); chk("rb_late_ack_bus_req", bus_req, 32'h0); chk("rb_late_ack_stall", stall, 32'h0);
        next_cycle(); bus_ack = 1'b0;
        mid(); chk("rb_late_ack_done", done, 32'h0); chk("rb_late_ack_rd", read_data, 32'h0);
        next_cycle(); issue(1'b0, 2'b10, 1'b0, 32'h100, 32'h0);
        next_cycle(); bus_ack = 1'b1; bus_rdata = 32'h1357_9BDF;
        mid(); chk("rb_next_bus_addr", bus_addr, 32'h100);
        next_cycle(); bus_ack = 1'b0;
        mid(); chk("rb_next_done", done, 32'h1); chk("rb_next_err", err, 32'h0);
        chk("rb_next_read_data", read_data, 32'h1357_9BDF);
        next_cycle(); idle_inputs();
        mid(); chk("rb_next_idle_done", done, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
